// File: rtl/qdi2bin_1of2_if.sv
// Channel bundle for the e1of2 receiver: dual-rail input with enable, and the
// buffered binary output with its valid/ready handshake and status.
interface qdi2bin_1of2_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]    L;
    logic          Le;
    logic          dout;
    logic          dvalid;
    logic          drdy;
    logic [CW-1:0] count;
    logic          err;

    // master is the side that owns the QDI sender and the binary consumer
    modport master (
        output L, drdy,
        input  Le, dout, dvalid, count, err
    );

    modport slave (
        input  L, drdy,
        output Le, dout, dvalid, count, err
    );
endinterface

// File: rtl/qdi2bin_1of2.sv
// Clocked receiver for an e1of2 channel: synchronizes the rails, runs the
// four-phase enable handshake and buffers decoded bits in a small FIFO.
module qdi2bin_1of2 #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  nRESET,
    qdi2bin_1of2_if.slave         bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        WAIT_VALID,
        WAIT_NEUTRAL
    } state_t;

    logic [SYNC_STAGES-1:0] sync0;
    logic [SYNC_STAGES-1:0] sync1;
    logic [SYNC_STAGES-1:0] arm;
    logic [1:0]             ls;
    logic                   armed;

    state_t                 state_q;
    state_t                 state_d;
    logic                   le_q;
    logic                   le_d;
    logic                   push;
    logic                   pop;
    logic                   set_err;
    logic                   err_q;

    logic                   mem [DEPTH];
    logic [AW-1:0]          wrptr;
    logic [AW-1:0]          rdptr;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_d;
    logic                   full;
    logic                   full_d;
    logic                   nonempty;

    // arm fills once the synchronizers hold only post-reset samples, so a
    // token left on L across reset can never be mistaken for neutral
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            sync0 <= '0;
            sync1 <= '0;
            arm   <= '0;
        end else begin
            sync0 <= {sync0[SYNC_STAGES-2:0], bus.L[0]};
            sync1 <= {sync1[SYNC_STAGES-2:0], bus.L[1]};
            arm   <= {arm[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign ls       = {sync1[SYNC_STAGES-1], sync0[SYNC_STAGES-1]};
    assign armed    = arm[SYNC_STAGES-1];
    assign nonempty = (cnt != '0);
    assign full     = (cnt == CW'(DEPTH));
    assign pop      = nonempty & bus.drdy;

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        set_err = 1'b0;
        case (state_q)
            WAIT_VALID: begin
                if (ls == 2'b11) begin
                    set_err = 1'b1;
                    state_d = WAIT_NEUTRAL;
                end else if (ls != 2'b00 && !full) begin
                    push    = 1'b1;
                    state_d = WAIT_NEUTRAL;
                end
            end
            WAIT_NEUTRAL: begin
                if (armed && ls == 2'b00) begin
                    state_d = WAIT_VALID;
                end
            end
            default: state_d = WAIT_NEUTRAL;
        endcase
    end

    always_comb begin
        cnt_d = cnt;
        case ({push, pop})
            2'b10:   cnt_d = cnt + 1'b1;
            2'b01:   cnt_d = cnt - 1'b1;
            default: cnt_d = cnt;
        endcase
    end

    // Le looks ahead at the post-update occupancy so a pop reopens it at once
    assign full_d = (cnt_d == CW'(DEPTH));
    assign le_d   = (state_d == WAIT_VALID) && !full_d;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= WAIT_NEUTRAL;
            le_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            le_q    <= le_d;
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 1'b0;
            end
            wrptr <= '0;
            rdptr <= '0;
            cnt   <= '0;
        end else begin
            if (push) begin
                mem[wrptr] <= ls[1];
                wrptr      <= wrptr + 1'b1;
            end
            if (pop) begin
                rdptr <= rdptr + 1'b1;
            end
            cnt <= cnt_d;
        end
    end

    assign bus.Le     = le_q;
    assign bus.dout   = mem[rdptr];
    assign bus.dvalid = nonempty;
    assign bus.count  = cnt;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_qdi2bin_1of2.sv
// Directed bench for qdi2bin_1of2: four-phase sender and valid/ready consumer
// driven by hand, every expected value worked out from the handshake timing.
module tb_qdi2bin_1of2;
    localparam int DEPTH = 4;
    localparam int S     = 2;

    logic CLK;
    logic nRESET;
    int   vectors;
    int   miscompares;

    qdi2bin_1of2_if #(.DEPTH(DEPTH)) q ();

    qdi2bin_1of2 #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (S)
    ) dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .bus    (q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // inputs change and outputs are sampled 1 ns after a rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drive_token(input logic b);
        q.L = b ? 2'b10 : 2'b01;
        tick(S + 1);
    endtask

    task automatic drive_neutral();
        q.L = 2'b00;
        tick(S + 1);
    endtask

    task automatic test_reset();
        nRESET = 1'b0;
        q.L    = 2'b10;
        q.drdy = 1'b0;
        tick(3);
        vectors++; if (q.Le !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_le: got %b want 0", q.Le); end
        vectors++; if (q.dvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_dvalid: got %b want 0", q.dvalid); end
        vectors++; if (q.count !== 3'd0) begin miscompares++; $display("[TB] FAIL rst_count: got %0d want 0", q.count); end
        vectors++; if (q.err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_err: got %b want 0", q.err); end
        vectors++; if (q.dout !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_dout: got %b want 0", q.dout); end
        nRESET = 1'b1;
        tick(S + 4);
        vectors++; if (q.Le !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_held_le: got %b want 0", q.Le); end
        vectors++; if (q.dvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_held_dvalid: got %b want 0", q.dvalid); end
        vectors++; if (q.count !== 3'd0) begin miscompares++; $display("[TB] FAIL rst_held_count: got %0d want 0", q.count); end
        q.L = 2'b00;
        tick(S);
        vectors++; if (q.Le !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_neutral_early_le: got %b want 0", q.Le); end
        tick(1);
        vectors++; if (q.Le !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_neutral_le: got %b want 1", q.Le); end
    endtask

    task automatic test_single_tokens();
        logic bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        q.drdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q.L = bits[i] ? 2'b10 : 2'b01;
            tick(S);
            vectors++; if (q.Le !== 1'b1) begin miscompares++; $display("[TB] FAIL single_le_before[%0d]: got %b want 1", i, q.Le); end
            vectors++; if (q.dvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_dvalid_before[%0d]: got %b want 0", i, q.dvalid); end
            tick(1);
            vectors++; if (q.Le !== 1'b0) begin miscompares++; $display("[TB] FAIL single_le_fall[%0d]: got %b want 0", i, q.Le); end
            vectors++; if (q.dvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_dvalid[%0d]: got %b want 1", i, q.dvalid); end
            vectors++; if (q.dout !== bits[i]) begin miscompares++; $display("[TB] FAIL single_dout[%0d]: got %b want %b", i, q.dout, bits[i]); end
            tick(1);
            vectors++; if (q.dvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_dvalid_1cyc[%0d]: got %b want 0", i, q.dvalid); end
            q.L = 2'b00;
            tick(S);
            vectors++; if (q.Le !== 1'b0) begin miscompares++; $display("[TB] FAIL single_le_neutral_early[%0d]: got %b want 0", i, q.Le); end
            tick(1);
            vectors++; if (q.Le !== 1'b1) begin miscompares++; $display("[TB] FAIL single_le_rise[%0d]: got %b want 1", i, q.Le); end
        end
    endtask

    task automatic test_backpressure();
        logic first [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic drain [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        q.drdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_token(first[i]);
            vectors++; if (q.count !== 3'(i + 1)) begin miscompares++; $display("[TB] FAIL bp_count[%0d]: got %0d want %0d", i, q.count, i + 1); end
            drive_neutral();
        end
        vectors++; if (q.count !== 3'd4) begin miscompares++; $display("[TB] FAIL bp_full_count: got %0d want 4", q.count); end
        vectors++; if (q.Le !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_full_le: got %b want 0", q.Le); end
        tick(3);
        vectors++; if (q.Le !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_full_le_hold: got %b want 0", q.Le); end
        vectors++; if (q.dout !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_head: got %b want 1", q.dout); end
        q.drdy = 1'b1;
        tick(1);
        q.drdy = 1'b0;
        vectors++; if (q.count !== 3'd3) begin miscompares++; $display("[TB] FAIL bp_pop_count: got %0d want 3", q.count); end
        vectors++; if (q.Le !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_pop_le: got %b want 1", q.Le); end
        drive_token(1'b1);
        vectors++; if (q.count !== 3'd4) begin miscompares++; $display("[TB] FAIL bp_fifth_count: got %0d want 4", q.count); end
        vectors++; if (q.Le !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_fifth_le: got %b want 0", q.Le); end
        drive_neutral();
        vectors++; if (q.Le !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_fifth_neutral_le: got %b want 0", q.Le); end
        q.drdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (q.dvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_drain_dvalid[%0d]: got %b want 1", i, q.dvalid); end
            vectors++; if (q.dout !== drain[i]) begin miscompares++; $display("[TB] FAIL bp_drain_dout[%0d]: got %b want %b", i, q.dout, drain[i]); end
            tick(1);
        end
        vectors++; if (q.count !== 3'd0) begin miscompares++; $display("[TB] FAIL bp_drain_count: got %0d want 0", q.count); end
        vectors++; if (q.Le !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_drain_le: got %b want 1", q.Le); end
    endtask

    task automatic test_simultaneous();
        logic rest [3] = '{1'b1, 1'b0, 1'b0};
        q.drdy = 1'b0;
        drive_token(1'b1); drive_neutral();
        drive_token(1'b1); drive_neutral();
        drive_token(1'b0); drive_neutral();
        vectors++; if (q.count !== 3'd3) begin miscompares++; $display("[TB] FAIL sim_pre_count: got %0d want 3", q.count); end
        vectors++; if (q.Le !== 1'b1) begin miscompares++; $display("[TB] FAIL sim_pre_le: got %b want 1", q.Le); end
        q.L = 2'b01;
        tick(S);
        q.drdy = 1'b1;
        tick(1);
        q.drdy = 1'b0;
        vectors++; if (q.count !== 3'd3) begin miscompares++; $display("[TB] FAIL sim_count: got %0d want 3", q.count); end
        vectors++; if (q.Le !== 1'b0) begin miscompares++; $display("[TB] FAIL sim_le_ack: got %b want 0", q.Le); end
        drive_neutral();
        vectors++; if (q.Le !== 1'b1) begin miscompares++; $display("[TB] FAIL sim_le_return: got %b want 1", q.Le); end
        vectors++; if (q.count !== 3'd3) begin miscompares++; $display("[TB] FAIL sim_count_return: got %0d want 3", q.count); end
        q.drdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (q.dout !== rest[i]) begin miscompares++; $display("[TB] FAIL sim_drain_dout[%0d]: got %b want %b", i, q.dout, rest[i]); end
            tick(1);
        end
        vectors++; if (q.dvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL sim_drain_dvalid: got %b want 0", q.dvalid); end
    endtask

    task automatic test_illegal();
        q.drdy = 1'b1;
        q.L    = 2'b11;
        tick(S);
        vectors++; if (q.err !== 1'b0) begin miscompares++; $display("[TB] FAIL ill_err_early: got %b want 0", q.err); end
        tick(1);
        vectors++; if (q.err !== 1'b1) begin miscompares++; $display("[TB] FAIL ill_err: got %b want 1", q.err); end
        vectors++; if (q.Le !== 1'b0) begin miscompares++; $display("[TB] FAIL ill_le: got %b want 0", q.Le); end
        vectors++; if (q.dvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL ill_dvalid: got %b want 0", q.dvalid); end
        vectors++; if (q.count !== 3'd0) begin miscompares++; $display("[TB] FAIL ill_count: got %0d want 0", q.count); end
        drive_neutral();
        vectors++; if (q.Le !== 1'b1) begin miscompares++; $display("[TB] FAIL ill_neutral_le: got %b want 1", q.Le); end
        vectors++; if (q.err !== 1'b1) begin miscompares++; $display("[TB] FAIL ill_err_sticky: got %b want 1", q.err); end
        drive_token(1'b0);
        vectors++; if (q.dvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL ill_next_dvalid: got %b want 1", q.dvalid); end
        vectors++; if (q.dout !== 1'b0) begin miscompares++; $display("[TB] FAIL ill_next_dout: got %b want 0", q.dout); end
        drive_neutral();
        vectors++; if (q.Le !== 1'b1) begin miscompares++; $display("[TB] FAIL ill_next_le: got %b want 1", q.Le); end
        vectors++; if (q.err !== 1'b1) begin miscompares++; $display("[TB] FAIL ill_err_final: got %b want 1", q.err); end
    endtask

    task automatic test_mid_reset();
        q.drdy = 1'b0;
        drive_token(1'b1);
        drive_neutral();
        drive_token(1'b0);
        vectors++; if (q.count !== 3'd2) begin miscompares++; $display("[TB] FAIL mr_pre_count: got %0d want 2", q.count); end
        nRESET = 1'b0;
        #1;
        vectors++; if (q.count !== 3'd0) begin miscompares++; $display("[TB] FAIL mr_count: got %0d want 0", q.count); end
        vectors++; if (q.dvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL mr_dvalid: got %b want 0", q.dvalid); end
        vectors++; if (q.err !== 1'b0) begin miscompares++; $display("[TB] FAIL mr_err: got %b want 0", q.err); end
        vectors++; if (q.Le !== 1'b0) begin miscompares++; $display("[TB] FAIL mr_le: got %b want 0", q.Le); end
        tick(2);
        nRESET = 1'b1;
        tick(S + 3);
        vectors++; if (q.Le !== 1'b0) begin miscompares++; $display("[TB] FAIL mr_held_le: got %b want 0", q.Le); end
        vectors++; if (q.count !== 3'd0) begin miscompares++; $display("[TB] FAIL mr_held_count: got %0d want 0", q.count); end
        drive_neutral();
        vectors++; if (q.Le !== 1'b1) begin miscompares++; $display("[TB] FAIL mr_resume_le: got %b want 1", q.Le); end
        q.drdy = 1'b1;
        drive_token(1'b1);
        vectors++; if (q.dvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL mr_tok_dvalid: got %b want 1", q.dvalid); end
        vectors++; if (q.dout !== 1'b1) begin miscompares++; $display("[TB] FAIL mr_tok_dout: got %b want 1", q.dout); end
        drive_neutral();
        vectors++; if (q.Le !== 1'b1) begin miscompares++; $display("[TB] FAIL mr_tok_le: got %b want 1", q.Le); end
        vectors++; if (q.count !== 3'd0) begin miscompares++; $display("[TB] FAIL mr_tok_count: got %0d want 0", q.count); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        nRESET      = 1'b0;
        q.L         = 2'b10;
        q.drdy      = 1'b0;
        test_reset();
        test_single_tokens();
        test_backpressure();
        test_simultaneous();
        test_illegal();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
